// File: rtl/uart_pkg.sv
// Shared constants for the UART transmitter: FSM encoding, parity modes
// and a constant-evaluable log2 used to size the baud counter.
package uart_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_PAR   = 3'd3;
    localparam logic [2:0] ST_STOP  = 3'd4;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    // Ceiling log2; callers guarantee value >= 2.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake between a print stage (master) and the UART serializer (slave).
interface uart_tx_if;

    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic       tx_done;

    modport master (
        output tx_start,
        output tx_data,
        input  tx_busy,
        input  tx_done
    );

    modport slave (
        input  tx_start,
        input  tx_data,
        output tx_busy,
        output tx_done
    );

endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period counter: runs 0..CLKS_PER_BIT-1 while enabled, cleared at frame start.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick,
    output logic pre_tick
);

    localparam int CNT_W = clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] PRE  = CNT_W'(CLKS_PER_BIT - 2);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    // pre_tick lets the FSM register tx_done so it lands on the final bit clock.
    assign tick     = en && (cnt == LAST);
    assign pre_tick = en && (cnt == PRE);

endmodule

// File: rtl/uart_tx.sv
// 8-bit UART serializer: start, 8 data bits LSB-first, optional parity, 1 or 2 stop bits.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic        clk,
    input  logic        rst,
    uart_tx_if.slave    bus,
    output logic        tx
);

    localparam bit   HAS_PAR   = (PARITY != PARITY_NONE);
    localparam logic STOP_LAST = (STOP_BITS == 2);

    logic [2:0] state;
    logic [7:0] shreg;
    logic [2:0] bit_idx;
    logic       par_bit;
    logic       stop_cnt;
    logic       tx_q;
    logic       busy_q;
    logic       done_q;
    logic       tick;
    logic       pre_tick;
    logic       accept;

    assign accept = (state == ST_IDLE) && bus.tx_start;

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .rst      (rst),
        .clr      (accept),
        .en       (state != ST_IDLE),
        .tick     (tick),
        .pre_tick (pre_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            bit_idx  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            stop_cnt <= 1'b0;
        end else begin
            // Raised one clock early so the registered pulse covers the last stop clock.
            done_q <= (state == ST_STOP) && pre_tick && (stop_cnt == STOP_LAST);
            case (state)
                ST_IDLE: begin
                    if (bus.tx_start) begin
                        shreg   <= bus.tx_data;
                        par_bit <= (PARITY == PARITY_ODD) ? ~^bus.tx_data : ^bus.tx_data;
                        state   <= ST_START;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        state   <= ST_DATA;
                        bit_idx <= '0;
                        tx_q    <= shreg[0];
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (bit_idx == 3'd7) begin
                            stop_cnt <= 1'b0;
                            if (HAS_PAR) begin
                                state <= ST_PAR;
                                tx_q  <= par_bit;
                            end else begin
                                state <= ST_STOP;
                                tx_q  <= 1'b1;
                            end
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            shreg   <= {1'b0, shreg[7:1]};
                            tx_q    <= shreg[1];
                        end
                    end
                end
                ST_PAR: begin
                    if (tick) begin
                        state    <= ST_STOP;
                        tx_q     <= 1'b1;
                        stop_cnt <= 1'b0;
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        if (stop_cnt == STOP_LAST) begin
                            state  <= ST_IDLE;
                            busy_q <= 1'b0;
                        end else begin
                            stop_cnt <= stop_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign tx          = tx_q;
    assign bus.tx_busy = busy_q;
    assign bus.tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: four configurations side by side, frame shapes,
// parity, back-to-back, a print-stage style byte stream and mid-frame reset.
module tb_uart_tx;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [3:0] st;
    logic [7:0] dt [4];
    logic [3:0] txw;
    logic [3:0] busyw;
    logic [3:0] donew;

    uart_tx_if bus0 ();
    uart_tx_if buse ();
    uart_tx_if buso ();
    uart_tx_if bus2 ();

    assign bus0.tx_start = st[0];
    assign bus0.tx_data  = dt[0];
    assign buse.tx_start = st[1];
    assign buse.tx_data  = dt[1];
    assign buso.tx_start = st[2];
    assign buso.tx_data  = dt[2];
    assign bus2.tx_start = st[3];
    assign bus2.tx_data  = dt[3];

    assign busyw = {bus2.tx_busy, buso.tx_busy, buse.tx_busy, bus0.tx_busy};
    assign donew = {bus2.tx_done, buso.tx_done, buse.tx_done, bus0.tx_done};

    uart_tx #(.CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0), .tx(txw[0]));
    uart_tx #(.CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(1)) dute (
        .clk(clk), .rst(rst), .bus(buse), .tx(txw[1]));
    uart_tx #(.CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1)) duto (
        .clk(clk), .rst(rst), .bus(buso), .tx(txw[2]));
    uart_tx #(.CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2), .tx(txw[3]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Receiver on dut0's line (4 clocks/bit), sampling each bit near its middle.
    logic       rx_en;
    logic       rx_act;
    int         rx_t;
    logic [7:0] rx_sh;
    logic [7:0] rx_q [$];

    always @(negedge clk) begin
        if (!rx_en || rst) begin
            rx_act <= 1'b0;
        end else if (!rx_act) begin
            if (txw[0] == 1'b0) begin
                rx_act <= 1'b1;
                rx_t   <= 1;
            end
        end else begin
            rx_t <= rx_t + 1;
            if ((rx_t + 1) >= 7 && (rx_t + 1) <= 35 && ((rx_t + 1 - 7) % 4) == 0)
                rx_sh <= {txw[0], rx_sh[7:1]};
            if ((rx_t + 1) == 39) begin
                rx_act <= 1'b0;
                rx_q.push_back(rx_sh);
            end
        end
    end

    // Drives one or more frames and checks tx/busy/done every clock.
    task automatic run_frame(input int idx, input logic [7:0] data, input logic [11:0] exp,
                             input int nbits, input int nframes, input bit hold);
        int   len;
        int   per;
        int   pos;
        logic e_tx;
        logic e_busy;
        logic e_done;
        len = nbits * 4;
        per = len + 1;
        st[idx] = 1'b1;
        dt[idx] = data;
        checks++;
        if (busyw[idx] !== 1'b0) begin
            errors++;
            $display("FAIL pre_accept_busy dut%0d got %b exp 0", idx, busyw[idx]);
        end
        for (int c = 1; c <= nframes * per; c++) begin
            @(negedge clk);
            pos = (c - 1) % per;
            if (!hold && c == 1) begin
                st[idx] = 1'b0;
                dt[idx] = ~data;
            end
            if (hold && c == (nframes - 1) * per + 2) st[idx] = 1'b0;
            e_tx   = (pos < len) ? exp[pos / 4] : 1'b1;
            e_busy = (pos < len);
            e_done = (pos == len - 1);
            checks += 3;
            if (txw[idx] !== e_tx) begin
                errors++;
                $display("FAIL frame_tx dut%0d c=%0d got %b exp %b", idx, c, txw[idx], e_tx);
            end
            if (busyw[idx] !== e_busy) begin
                errors++;
                $display("FAIL frame_busy dut%0d c=%0d got %b exp %b", idx, c, busyw[idx], e_busy);
            end
            if (donew[idx] !== e_done) begin
                errors++;
                $display("FAIL frame_done dut%0d c=%0d got %b exp %b", idx, c, donew[idx], e_done);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        st  = 4'hF;
        for (int i = 0; i < 4; i++) dt[i] = 8'h55;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks += 3;
            if (txw !== 4'hF) begin
                errors++;
                $display("FAIL reset_tx c=%0d got %b exp 1111", c, txw);
            end
            if (busyw !== 4'h0) begin
                errors++;
                $display("FAIL reset_busy c=%0d got %b exp 0000", c, busyw);
            end
            if (donew !== 4'h0) begin
                errors++;
                $display("FAIL reset_done c=%0d got %b exp 0000", c, donew);
            end
        end
        rst = 1'b0;
        st  = 4'h0;
        @(negedge clk);
        checks++;
        if (busyw !== 4'h0 || txw !== 4'hF) begin
            errors++;
            $display("FAIL reset_release busy got %b exp 0000 tx got %b exp 1111", busyw, txw);
        end
    endtask

    task automatic test_basic();
        run_frame(0, 8'h31, 12'h262, 10, 1, 1'b0);
    endtask

    task automatic test_parity();
        run_frame(1, 8'h07, 12'h60E, 11, 1, 1'b0);
        run_frame(2, 8'h07, 12'h40E, 11, 1, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_frame(3, 8'hA5, 12'h74A, 11, 3, 1'b1);
    endtask

    task automatic test_print();
        logic [7:0] msg [5];
        int         n;
        msg[0] = 8'h30;
        msg[1] = 8'h34;
        msg[2] = 8'h32;
        msg[3] = 8'h0D;
        msg[4] = 8'h0A;
        rx_q.delete();
        rx_en = 1'b1;
        @(negedge clk);
        for (int b = 0; b < 5; b++) begin
            st[0] = 1'b1;
            dt[0] = msg[b];
            @(negedge clk);
            checks++;
            if (busyw[0] !== 1'b1) begin
                errors++;
                $display("FAIL print_busy_seen byte=%0d got %b exp 1", b, busyw[0]);
            end
            @(negedge clk);
            st[0] = 1'b0;
            dt[0] = 8'h00;
            n = 0;
            while (busyw[0] && n < 100) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (busyw[0] !== 1'b0) begin
                errors++;
                $display("FAIL print_timeout byte=%0d busy got %b exp 0", b, busyw[0]);
            end
        end
        repeat (60) @(negedge clk);
        rx_en = 1'b0;
        checks++;
        if (rx_q.size() != 5) begin
            errors++;
            $display("FAIL print_count got %0d exp 5", rx_q.size());
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (i >= rx_q.size()) begin
                errors++;
                $display("FAIL print_byte%0d got none exp %h", i, msg[i]);
            end else if (rx_q[i] !== msg[i]) begin
                errors++;
                $display("FAIL print_byte%0d got %h exp %h", i, rx_q[i], msg[i]);
            end
        end
    endtask

    task automatic test_midreset();
        int done_seen;
        st[0] = 1'b1;
        dt[0] = 8'hFF;
        @(negedge clk);
        st[0] = 1'b0;
        for (int c = 2; c <= 18; c++) @(negedge clk);
        checks += 2;
        if (busyw[0] !== 1'b1) begin
            errors++;
            $display("FAIL midreset_busy_before got %b exp 1", busyw[0]);
        end
        if (txw[0] !== 1'b1) begin
            errors++;
            $display("FAIL midreset_bit3 got %b exp 1", txw[0]);
        end
        rst = 1'b1;
        @(negedge clk);
        checks += 3;
        if (txw[0] !== 1'b1) begin
            errors++;
            $display("FAIL midreset_tx got %b exp 1", txw[0]);
        end
        if (busyw[0] !== 1'b0) begin
            errors++;
            $display("FAIL midreset_busy got %b exp 0", busyw[0]);
        end
        if (donew[0] !== 1'b0) begin
            errors++;
            $display("FAIL midreset_done got %b exp 0", donew[0]);
        end
        rst = 1'b0;
        done_seen = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (donew[0] !== 1'b0 || busyw[0] !== 1'b0 || txw[0] !== 1'b1) done_seen++;
        end
        checks++;
        if (done_seen != 0) begin
            errors++;
            $display("FAIL midreset_quiet got %0d active cycles exp 0", done_seen);
        end
        run_frame(0, 8'hFF, 12'h3FE, 10, 1, 1'b0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rx_en  = 1'b0;
        rst    = 1'b1;
        st     = 4'h0;
        for (int i = 0; i < 4; i++) dt[i] = 8'h00;
        test_reset();
        test_basic();
        test_parity();
        test_back_to_back();
        test_print();
        test_midreset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
